// File: rtl/trashbin_gpio_pkg.sv
// -----------------------------------------------------------------------------
// trashbin_gpio_pkg
// Shared constants and helpers for the GPIO input conditioning path.
//   DEF_NUM_SW / DEF_NUM_KEY / DEF_DEBOUNCE_CYCLES : default sizing
//   MAX_DEBOUNCE_CYCLES                            : largest legal debounce time
//   debounce_cnt_width()                           : counter width for a given
//                                                    debounce time
// -----------------------------------------------------------------------------
package trashbin_gpio_pkg;

  localparam int DEF_NUM_SW          = 10;
  localparam int DEF_NUM_KEY         = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int MAX_DEBOUNCE_CYCLES = 1 << 20;

  // Width able to hold 0..cycles inclusive.
  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner_if
// Bundles the board-facing raw inputs and the conditioned outputs of
// gpio_input_conditioner.
//   w_SwitchesRaw   [NUM_SW]  raw slide switches (active-high, asynchronous)
//   w_KeysRaw       [NUM_KEY] raw push buttons (active-low, asynchronous)
//   w_KeyLatchClear [NUM_KEY] per-key clear strobe for the sticky flags
//   w_Switches      [NUM_SW]  debounced switch levels (active-high)
//   w_Keys          [NUM_KEY] debounced key levels (active-low)
//   w_KeyPressPulse [NUM_KEY] one-cycle pulse per debounced press
//   w_KeyLatched    [NUM_KEY] sticky press flags
// Modports: master = board/consumer side, slave = the conditioner.
// -----------------------------------------------------------------------------
interface gpio_input_conditioner_if
  import trashbin_gpio_pkg::*;
#(
  parameter int NUM_SW  = DEF_NUM_SW,
  parameter int NUM_KEY = DEF_NUM_KEY
);

  logic [NUM_SW-1:0]  w_SwitchesRaw;
  logic [NUM_KEY-1:0] w_KeysRaw;
  logic [NUM_KEY-1:0] w_KeyLatchClear;
  logic [NUM_SW-1:0]  w_Switches;
  logic [NUM_KEY-1:0] w_Keys;
  logic [NUM_KEY-1:0] w_KeyPressPulse;
  logic [NUM_KEY-1:0] w_KeyLatched;

  modport master (
    output w_SwitchesRaw,
    output w_KeysRaw,
    output w_KeyLatchClear,
    input  w_Switches,
    input  w_Keys,
    input  w_KeyPressPulse,
    input  w_KeyLatched
  );

  modport slave (
    input  w_SwitchesRaw,
    input  w_KeysRaw,
    input  w_KeyLatchClear,
    output w_Switches,
    output w_Keys,
    output w_KeyPressPulse,
    output w_KeyLatched
  );

endinterface

// File: rtl/gpio_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_debounce_bit
// One input bit: two-flop synchronizer followed by a counting debouncer.
// The stable level only follows the synchronized level after DEBOUNCE_CYCLES
// consecutive mismatching cycles; any matching cycle restarts the count.
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset (all flops to RESET_VALUE,
//                counter to 0)
//   raw_in     : asynchronous raw input
//   stable_out : debounced level
// -----------------------------------------------------------------------------
module gpio_debounce_bit
  import trashbin_gpio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic stable_out
);

  localparam int             CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      // The mismatch cycle that finds the counter at its last value is the
      // DEBOUNCE_CYCLES-th in a row, so accept the new level now.
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= RESET_VALUE;
      sync2_q  <= RESET_VALUE;
      stable_q <= RESET_VALUE;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_out = stable_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner
// Synchronizes and debounces the board slide switches and push buttons, and
// derives a one-cycle press pulse plus an optional sticky press flag per key.
// Ports:
//   CoreClock   : sole clock, rising edge
//   CoreReset_n : asynchronous active-low reset
//   gpio        : gpio_input_conditioner_if.slave (raw inputs, latch clears,
//                 debounced levels, press pulses, sticky flags)
// The interface instance must use the same NUM_SW / NUM_KEY as this module.
// Build option:
//   GPIO_COND_KEY_LATCH_EN : when defined, w_KeyLatched is a set-dominant
//                            sticky flag per key cleared by w_KeyLatchClear;
//                            otherwise w_KeyLatched is 0 and the clears are
//                            ignored.
// -----------------------------------------------------------------------------
module gpio_input_conditioner
  import trashbin_gpio_pkg::*;
#(
  parameter int NUM_SW          = DEF_NUM_SW,
  parameter int NUM_KEY         = DEF_NUM_KEY,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                     CoreClock,
  input  logic                     CoreReset_n,
  gpio_input_conditioner_if.slave  gpio
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > MAX_DEBOUNCE_CYCLES) begin : g_bad_cycles
    $error("gpio_input_conditioner: DEBOUNCE_CYCLES must be in 1..2^20");
  end

  logic [NUM_SW-1:0]  sw_stable;
  logic [NUM_KEY-1:0] key_stable;

  genvar gi;

  for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (1'b0)
    ) u_db (
      .clk        (CoreClock),
      .rst_n      (CoreReset_n),
      .raw_in     (gpio.w_SwitchesRaw[gi]),
      .stable_out (sw_stable[gi])
    );
  end

  // Keys are active-low, so they reset to the released level.
  for (gi = 0; gi < NUM_KEY; gi++) begin : g_key
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (1'b1)
    ) u_db (
      .clk        (CoreClock),
      .rst_n      (CoreReset_n),
      .raw_in     (gpio.w_KeysRaw[gi]),
      .stable_out (key_stable[gi])
    );
  end

  // Press detection: a registered 1->0 edge of the debounced key level.
  // key_prev_q resets to "released" so a key held through reset produces
  // exactly one pulse once its debounce completes.
  logic [NUM_KEY-1:0] key_prev_q, key_prev_d;
  logic [NUM_KEY-1:0] key_pulse_q, key_pulse_d;

  always_comb begin
    key_prev_d  = key_stable;
    key_pulse_d = key_prev_q & ~key_stable;
  end

  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) begin
      key_prev_q  <= '1;
      key_pulse_q <= '0;
    end else begin
      key_prev_q  <= key_prev_d;
      key_pulse_q <= key_pulse_d;
    end
  end

`ifdef GPIO_COND_KEY_LATCH_EN
  logic [NUM_KEY-1:0] key_latched_q, key_latched_d;

  // Set wins over a coincident clear so no press is ever lost.
  always_comb begin
    key_latched_d = key_pulse_q | (key_latched_q & ~gpio.w_KeyLatchClear);
  end

  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) begin
      key_latched_q <= '0;
    end else begin
      key_latched_q <= key_latched_d;
    end
  end

  assign gpio.w_KeyLatched = key_latched_q;
`else
  logic unused_latch_clear;
  assign unused_latch_clear = ^gpio.w_KeyLatchClear;
  assign gpio.w_KeyLatched  = '0;
`endif

  assign gpio.w_Switches      = sw_stable;
  assign gpio.w_Keys          = key_stable;
  assign gpio.w_KeyPressPulse = key_pulse_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gpio_input_conditioner
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES = 4, so a
// held raw change reaches the outputs 6 cycles after it is applied.
// Inputs are changed 1 ns after a rising edge and outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_gpio_input_conditioner;

  localparam int NSW  = 10;
  localparam int NKEY = 4;

`ifdef GPIO_COND_KEY_LATCH_EN
  localparam bit LATCH_ON = 1'b1;
`else
  localparam bit LATCH_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   pulse_cnt [NKEY];

  gpio_input_conditioner_if #(.NUM_SW(NSW), .NUM_KEY(NKEY)) gpio_bus ();

  gpio_input_conditioner #(
    .NUM_SW          (NSW),
    .NUM_KEY         (NKEY),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CoreClock   (clk),
    .CoreReset_n (rst_n),
    .gpio        (gpio_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, landing 1 ns after each rising edge and tallying pulses.
  task automatic ticks(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NKEY; k++) begin
        pulse_cnt[k] += int'(gpio_bus.w_KeyPressPulse[k]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int k = 0; k < NKEY; k++) pulse_cnt[k] = 0;
    rst_n = 1'b0;
    gpio_bus.w_SwitchesRaw   = '0;
    gpio_bus.w_KeysRaw       = '1;
    gpio_bus.w_KeyLatchClear = '0;

    // Reset state
    ticks(2);
    $display("reset: sw=%h keys=%h", gpio_bus.w_Switches, gpio_bus.w_Keys);
    check_eq("rst_sw",    32'(gpio_bus.w_Switches),      32'h000);
    check_eq("rst_keys",  32'(gpio_bus.w_Keys),          32'hF);
    check_eq("rst_pulse", 32'(gpio_bus.w_KeyPressPulse), 32'h0);
    check_eq("rst_latch", 32'(gpio_bus.w_KeyLatched),    32'h0);
    rst_n = 1'b1;
    ticks(3);

    // Switch 0 rises and is held: visible exactly 6 cycles later
    gpio_bus.w_SwitchesRaw = 10'h001;
    ticks(5);
    check_eq("sw0_at5", 32'(gpio_bus.w_Switches), 32'h000);
    ticks(1);
    check_eq("sw0_at6", 32'(gpio_bus.w_Switches), 32'h001);
    $display("sw0 rise: sw=%h", gpio_bus.w_Switches);

    // Key 2 bounces 0,1,0,1 then settles at 0
    gpio_bus.w_KeysRaw = 4'b1011; ticks(1);
    gpio_bus.w_KeysRaw = 4'b1111; ticks(1);
    gpio_bus.w_KeysRaw = 4'b1011; ticks(1);
    gpio_bus.w_KeysRaw = 4'b1111; ticks(1);
    gpio_bus.w_KeysRaw = 4'b1011;
    ticks(5);
    check_eq("key2_at5",     32'(gpio_bus.w_Keys),          32'hF);
    ticks(1);
    check_eq("key2_at6",     32'(gpio_bus.w_Keys),          32'hB);
    check_eq("key2_nopulse", 32'(gpio_bus.w_KeyPressPulse), 32'h0);
    ticks(1);
    check_eq("key2_pulse",   32'(gpio_bus.w_KeyPressPulse), 32'h4);
    ticks(1);
    check_eq("key2_pulse_end", 32'(gpio_bus.w_KeyPressPulse), 32'h0);
    ticks(4);
    check_eq("key2_pulse_count", 32'(pulse_cnt[2]), 32'd1);
    check_eq("key2_latched", 32'(gpio_bus.w_KeyLatched), LATCH_ON ? 32'h4 : 32'h0);
    gpio_bus.w_KeyLatchClear = 4'b0100; ticks(1);
    gpio_bus.w_KeyLatchClear = 4'b0000;
    check_eq("key2_cleared", 32'(gpio_bus.w_KeyLatched), 32'h0);
    gpio_bus.w_KeysRaw = 4'b1111;
    ticks(10);
    check_eq("key2_released",   32'(gpio_bus.w_Keys), 32'hF);
    check_eq("key2_no_release_pulse", 32'(pulse_cnt[2]), 32'd1);
    $display("key2 bounce: pulses=%0d", pulse_cnt[2]);

    // 3-cycle glitch on switch 5 must be rejected
    gpio_bus.w_SwitchesRaw = 10'h021;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) gpio_bus.w_SwitchesRaw = 10'h001;
      ticks(1);
      check_eq("sw5_glitch", 32'(gpio_bus.w_Switches), 32'h001);
    end
    $display("sw5 glitch: sw=%h", gpio_bus.w_Switches);

    // Key 1: clear one cycle after pulse, then clear coincident with 2nd pulse
    gpio_bus.w_KeysRaw = 4'b1101;
    ticks(7);
    check_eq("key1_pulse1", 32'(gpio_bus.w_KeyPressPulse), 32'h2);
    ticks(1);
    check_eq("key1_set1", 32'(gpio_bus.w_KeyLatched), LATCH_ON ? 32'h2 : 32'h0);
    gpio_bus.w_KeyLatchClear = 4'b0010; ticks(1);
    gpio_bus.w_KeyLatchClear = 4'b0000;
    check_eq("key1_clr1", 32'(gpio_bus.w_KeyLatched), 32'h0);
    gpio_bus.w_KeysRaw = 4'b1111;
    ticks(9);
    gpio_bus.w_KeysRaw = 4'b1101;
    ticks(7);
    check_eq("key1_pulse2", 32'(gpio_bus.w_KeyPressPulse), 32'h2);
    gpio_bus.w_KeyLatchClear = 4'b0010; ticks(1);
    gpio_bus.w_KeyLatchClear = 4'b0000;
    check_eq("key1_set_wins", 32'(gpio_bus.w_KeyLatched), LATCH_ON ? 32'h2 : 32'h0);
    ticks(2);
    check_eq("key1_stays_set", 32'(gpio_bus.w_KeyLatched), LATCH_ON ? 32'h2 : 32'h0);
    check_eq("key1_pulse_count", 32'(pulse_cnt[1]), 32'd2);
    gpio_bus.w_KeysRaw = 4'b1111;
    ticks(9);
    gpio_bus.w_KeyLatchClear = 4'b0010; ticks(1);
    gpio_bus.w_KeyLatchClear = 4'b0000;
    check_eq("key1_final_clr", 32'(gpio_bus.w_KeyLatched), 32'h0);
    $display("key1 latch: pulses=%0d", pulse_cnt[1]);

    // Key 0 press: pulse always, sticky flag only with the latch option
    gpio_bus.w_KeysRaw = 4'b1110;
    ticks(7);
    check_eq("key0_pulse", 32'(gpio_bus.w_KeyPressPulse), 32'h1);
    ticks(1);
    check_eq("key0_latched", 32'(gpio_bus.w_KeyLatched), LATCH_ON ? 32'h1 : 32'h0);
    gpio_bus.w_KeysRaw = 4'b1111;
    ticks(9);
    gpio_bus.w_KeyLatchClear = 4'b1111; ticks(1);
    gpio_bus.w_KeyLatchClear = 4'b0000;
    $display("key0 press: latched=%h", gpio_bus.w_KeyLatched);

    // Reset at count 3 of a pending switch 9 change, key 3 held across reset
    gpio_bus.w_SwitchesRaw = 10'h201;
    ticks(4);
    check_eq("sw9_pending", 32'(gpio_bus.w_Switches), 32'h001);
    gpio_bus.w_KeysRaw = 4'b0111;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_sw",    32'(gpio_bus.w_Switches),      32'h000);
    check_eq("midrst_keys",  32'(gpio_bus.w_Keys),          32'hF);
    check_eq("midrst_pulse", 32'(gpio_bus.w_KeyPressPulse), 32'h0);
    check_eq("midrst_latch", 32'(gpio_bus.w_KeyLatched),    32'h0);
    ticks(1);
    rst_n = 1'b1;
    ticks(5);
    check_eq("postrst_sw_at5",   32'(gpio_bus.w_Switches), 32'h000);
    check_eq("postrst_keys_at5", 32'(gpio_bus.w_Keys),     32'hF);
    ticks(1);
    check_eq("postrst_sw_at6",   32'(gpio_bus.w_Switches), 32'h201);
    check_eq("postrst_keys_at6", 32'(gpio_bus.w_Keys),     32'h7);
    ticks(1);
    check_eq("key3_pulse", 32'(gpio_bus.w_KeyPressPulse), 32'h8);
    ticks(5);
    check_eq("key3_pulse_count", 32'(pulse_cnt[3]), 32'd1);
    check_eq("key3_latched", 32'(gpio_bus.w_KeyLatched), LATCH_ON ? 32'h8 : 32'h0);
    $display("reset mid-debounce: sw=%h keys=%h", gpio_bus.w_Switches, gpio_bus.w_Keys);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpio_input_conditioner.md
GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 SHALL have parameter NUM_SW, default 10, number of slide-switch inputs.
REQ-002 SHALL have parameter NUM_KEY, default 4, number of push-button inputs.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a change; legal range 1..2^20.
REQ-004 SHALL have port CoreClock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port CoreReset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port w_SwitchesRaw  input  NUM_SW  raw board switches, asynchronous, active-high.
REQ-007 SHALL have port w_KeysRaw  input  NUM_KEY  raw board keys, asynchronous, active-low (0 = pressed).
REQ-008 SHALL have port w_Switches  output  NUM_SW  debounced switch levels, active-high, feeding BasicGPIO.
REQ-009 SHALL have port w_Keys  output  NUM_KEY  debounced key levels, active-low, feeding BasicGPIO.
REQ-010 SHALL have port w_KeyPressPulse  output  NUM_KEY  one-cycle active-high pulse per debounced press.
REQ-011 SHALL have port w_KeyLatched  output  NUM_KEY  sticky press flags (see Configuration).
REQ-012 SHALL have port w_KeyLatchClear  input  NUM_KEY  per-key clear strobe for w_KeyLatched, synchronous to CoreClock.

Function
REQ-013 SHALL pass every raw bit through a two-flop synchronizer before any other logic.
REQ-014 SHALL keep per bit a stable register and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-015 SHALL clear the counter on any cycle where synchronized value equals stable value.
REQ-016 SHALL increment the counter on each mismatch cycle; on the mismatch cycle where counter == DEBOUNCE_CYCLES-1, SHALL load stable from synchronized value and clear counter.
REQ-017 SHALL therefore update stable exactly DEBOUNCE_CYCLES consecutive mismatch cycles after the synchronized change; any single matching cycle restarts the count (glitch rejection).
REQ-018 SHALL drive w_Switches/w_Keys directly from stable registers; raw-pin-to-output latency = 2 + DEBOUNCE_CYCLES cycles.
REQ-019 SHALL assert w_KeyPressPulse[i] for exactly one cycle, the cycle after stable key i goes 1->0; release (0->1) produces no pulse.
REQ-020 SHALL treat each bit independently; simultaneous transitions on multiple bits produce simultaneous, independent results.
REQ-021 SHALL, for w_KeyLatched[i], set on w_KeyPressPulse[i], clear on w_KeyLatchClear[i]; simultaneous set and clear SHALL leave it set.
REQ-022 SHALL with DEBOUNCE_CYCLES = 1 accept any change on the first mismatch cycle (latency 3).
REQ-023 SHALL flag DEBOUNCE_CYCLES < 1 as an elaboration error.

Reset
REQ-024 SHALL on CoreReset_n low asynchronously set: switch synchronizers/stable = 0, key synchronizers/stable = 1 (released), counters = 0, w_KeyPressPulse = 0, w_KeyLatched = 0.
REQ-025 SHALL, on reset asserted mid-debounce, discard the pending count; after release, a held input needs a full 2 + DEBOUNCE_CYCLES cycles again.
REQ-026 SHALL not generate a press pulse for a key already held when reset deasserts until its debounce completes (then exactly one pulse).

Configuration
REQ-027 SHALL implement the sticky latch (REQ-021) only when macro GPIO_COND_KEY_LATCH_EN is defined.
REQ-028 SHALL, without GPIO_COND_KEY_LATCH_EN, tie w_KeyLatched to 0 and ignore w_KeyLatchClear; all other behaviour unchanged.

Structure
REQ-029 SHALL place default NUM_SW, NUM_KEY, DEBOUNCE_CYCLES constants and the counter-width function in shared package trashbin_gpio_pkg.
REQ-030 SHALL implement one bit of synchronizer+debouncer as sub-module gpio_debounce_bit (parameters DEBOUNCE_CYCLES, RESET_VALUE), instantiated NUM_SW + NUM_KEY times.

Verification (bench uses DEBOUNCE_CYCLES = 4)
REQ-031 SHALL cover: w_SwitchesRaw[0] 0->1 held -> w_Switches[0] = 1 exactly 6 cycles later.
REQ-032 SHALL cover: w_KeysRaw[2] bounce 0,1,0,1 (1 cycle each) then 0 held -> w_Keys[2] = 0 six cycles after final settle, exactly one w_KeyPressPulse[2].
REQ-033 SHALL cover: 3-cycle glitch on w_SwitchesRaw[5] -> w_Switches[5] never changes.
REQ-034 SHALL cover: key 1 pressed, w_KeyLatchClear[1] strobed on the pulse cycle+1 and again coincident with a second pulse -> latch clears then stays set.
REQ-035 SHALL cover: CoreReset_n low for 1 cycle at count 3 of a pending switch change -> outputs return to reset values; change appears 6 cycles after reset release.
REQ-036 SHALL cover: build without GPIO_COND_KEY_LATCH_EN, press key 0 -> pulse present, w_KeyLatched stays 0.
